// File: rtl/ctl_pkg.sv
// Shared types and widths for the control sequencer: opcodes, FSM states,
// ALU control-line bundle and the decoder's output record.
package ctl_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    typedef enum logic [3:0] {
        OP_NAD  = 4'h0,
        OP_SHR  = 4'h1,
        OP_SHL  = 4'h2,
        OP_LDI  = 4'h3,
        OP_LD   = 4'h4,
        OP_ST   = 4'h5,
        OP_JMP  = 4'h6,
        OP_JZ   = 4'h7,
        OP_HALT = 4'h8
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_OPERAND,
        S_EXEC,
        S_STORE,
        S_HALT
    } state_t;

    // Field order matches the ctl_* port order on the sequencer.
    typedef struct packed {
        logic nad;
        logic shr;
        logic shl;
        logic arg;
        logic read;
    } ctl_t;

    typedef struct packed {
        state_t nxt_state;
        ctl_t   ctl;
        logic   jmp;
        logic   jz;
        logic   illegal;
    } dec_t;

    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
        return pc + 1'b1;
    endfunction

endpackage

// File: rtl/ctl_decode.sv
// Pure combinational opcode decoder: instruction word -> post-DECODE state,
// ALU control select, branch kind and illegal-opcode flag.
module ctl_decode
    import ctl_pkg::*;
(
    input  logic [DATA_W-1:0] ir,
    output dec_t              dec
);

    always_comb begin
        dec           = '0;
        dec.nxt_state = S_HALT;
        case (opcode_t'(ir[15:12]))
            OP_NAD: begin
                dec.nxt_state = S_OPERAND;
                dec.ctl.nad   = 1'b1;
            end
            OP_SHR: begin
                dec.nxt_state = S_EXEC;
                dec.ctl.shr   = 1'b1;
            end
            OP_SHL: begin
                dec.nxt_state = S_EXEC;
                dec.ctl.shl   = 1'b1;
            end
            OP_LDI: begin
                dec.nxt_state = S_EXEC;
                dec.ctl.arg   = 1'b1;
            end
            OP_LD: begin
                dec.nxt_state = S_OPERAND;
                dec.ctl.read  = 1'b1;
            end
            OP_ST:   dec.nxt_state = S_STORE;
            OP_JMP: begin
                dec.nxt_state = S_EXEC;
                dec.jmp       = 1'b1;
            end
            OP_JZ: begin
                dec.nxt_state = S_EXEC;
                dec.jz        = 1'b1;
            end
            OP_HALT: dec.nxt_state = S_HALT;
            default: dec.illegal   = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctl_sequencer.sv
// Multi-cycle accumulator-machine sequencer: fetches and decodes instructions,
// drives the memory handshake and steers an external ALU via one-hot ctl lines.
module ctl_sequencer
    import ctl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              halted,
    output logic              error,
    output logic [ADDR_W-1:0] pc,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] acc_data,
    output logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] arg_data,
    output logic              ctl_nad,
    output logic              ctl_shr,
    output logic              ctl_shl,
    output logic              ctl_arg,
    output logic              ctl_read,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_is_zero
);

    state_t            state;
    logic [DATA_W-1:0] ir;
    ctl_t              ctl_q;
    dec_t              dec;
    logic [ADDR_W-1:0] operand;
    logic [ADDR_W-1:0] pc_exec;
    logic              ack;

    ctl_decode u_decode (
        .ir  (ir),
        .dec (dec)
    );

    assign operand  = ir[ADDR_W-1:0];
    assign arg_data = {{(DATA_W-ADDR_W){1'b0}}, operand};
    assign {ctl_nad, ctl_shr, ctl_shl, ctl_arg, ctl_read} = ctl_q;

    // An ack only counts against a live request.
    assign ack = mem_req & mem_ack;

    always_comb begin
        pc_exec = pc;
        if (dec.jmp || (dec.jz && alu_is_zero))
            pc_exec = operand;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            pc        <= '0;
            acc_data  <= '0;
            mem_data  <= '0;
            ir        <= '0;
            halted    <= 1'b0;
            error     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ctl_q     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state    <= S_FETCH;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                    end
                end
                S_FETCH: begin
                    if (ack) begin
                        ir      <= mem_rdata;
                        pc      <= pc_inc(pc);
                        mem_req <= 1'b0;
                        state   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    state  <= dec.nxt_state;
                    halted <= (dec.nxt_state == S_HALT);
                    error  <= dec.illegal;
                    case (dec.nxt_state)
                        S_OPERAND: begin
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= operand;
                        end
                        S_STORE: begin
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_addr  <= operand;
                            mem_wdata <= acc_data;
                        end
                        S_EXEC:  ctl_q <= dec.ctl;
                        default: ;
                    endcase
                end
                S_OPERAND: begin
                    if (ack) begin
                        mem_data <= mem_rdata;
                        mem_req  <= 1'b0;
                        ctl_q    <= dec.ctl;
                        state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // Jumps leave every ctl line low, so acc only moves on ALU ops.
                    if (ctl_q != '0)
                        acc_data <= alu_result;
                    ctl_q    <= '0;
                    pc       <= pc_exec;
                    state    <= S_FETCH;
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= pc_exec;
                end
                S_STORE: begin
                    // The next fetch request is issued back-to-back with the store.
                    if (ack) begin
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                        state    <= S_FETCH;
                    end
                end
                S_HALT: ;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ctl_sequencer.sv
// Scoreboarded bench for ctl_sequencer: expected memory transactions are queued
// per program and checked by the memory-side monitor as each handshake completes.
module tb_ctl_sequencer;

    typedef struct packed {
        logic        we;
        logic [11:0] addr;
        logic [15:0] data;
    } txn_t;

    logic        clk;
    logic        rst;
    logic        run;
    logic        halted;
    logic        error;
    logic [11:0] pc;
    logic        mem_req;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] acc_data;
    logic [15:0] mem_data;
    logic [15:0] arg_data;
    logic        ctl_nad, ctl_shr, ctl_shl, ctl_arg, ctl_read;
    logic [15:0] alu_result;
    logic        alu_is_zero;

    logic [15:0] mem [0:4095];
    txn_t        exp_q [$];
    int          n_chk  = 0;
    int          n_fail = 0;
    int          cyc    = 0;

    int          delay;
    logic        no_ack_en;
    logic [11:0] no_ack_addr;
    logic        stray_ack;
    logic        ack_m;
    logic [15:0] rdata_m;
    int          cnt;
    logic        pend;
    logic        cap_we;
    logic [11:0] cap_addr;
    logic [15:0] cap_wdata;
    logic        acked_prev;
    logic        acked_we_prev;
    logic        req_seen;
    int          req_cycles;
    int          nad_cycles;
    int          nad_cyc;
    int          fetch1_cyc;

    ctl_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .halted      (halted),
        .error       (error),
        .pc          (pc),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .acc_data    (acc_data),
        .mem_data    (mem_data),
        .arg_data    (arg_data),
        .ctl_nad     (ctl_nad),
        .ctl_shr     (ctl_shr),
        .ctl_shl     (ctl_shl),
        .ctl_arg     (ctl_arg),
        .ctl_read    (ctl_read),
        .alu_result  (alu_result),
        .alu_is_zero (alu_is_zero)
    );

    // Reference ALU: NAD is NAND of acc and operand register.
    assign alu_result = ctl_nad  ? ~(acc_data & mem_data) :
                        ctl_shr  ? (acc_data >> 1)        :
                        ctl_shl  ? (acc_data << 1)        :
                        ctl_arg  ? arg_data               :
                        ctl_read ? mem_data               : acc_data;
    assign alu_is_zero = (acc_data == 16'h0);
    assign mem_ack     = ack_m | stray_ack;
    assign mem_rdata   = rdata_m;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Memory model plus monitor: acks after `delay` extra cycles, checks request
    // stability while waiting and pops the scoreboard on each completed handshake.
    always @(negedge clk) begin
        if (rst) begin
            ack_m      = 1'b0;
            pend       = 1'b0;
            cnt        = 0;
            acked_prev = 1'b0;
            rdata_m    = 16'hDEAD;
        end else begin
            if (acked_prev) begin
                chk("we_after_ack", mem_we, 0);
                if (!acked_we_prev) chk("req_drop_after_ack", mem_req, 0);
            end
            acked_prev = 1'b0;
            ack_m      = 1'b0;
            if (mem_req) begin
                req_seen = 1'b1;
                req_cycles++;
                if (!pend) begin
                    pend      = 1'b1;
                    cnt       = 0;
                    cap_we    = mem_we;
                    cap_addr  = mem_addr;
                    cap_wdata = mem_wdata;
                end else begin
                    chk("hold_we", mem_we, cap_we);
                    chk("hold_addr", mem_addr, cap_addr);
                    chk("hold_wdata", mem_wdata, cap_wdata);
                end
                rdata_m = mem[mem_addr];
                if (!(no_ack_en && mem_addr == no_ack_addr) && cnt >= delay) begin
                    txn_t e;
                    ack_m         = 1'b1;
                    pend          = 1'b0;
                    acked_prev    = 1'b1;
                    acked_we_prev = mem_we;
                    if (mem_we) mem[mem_addr] = mem_wdata;
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_txn: got we=%0b addr=%0h, required no transaction", mem_we, mem_addr);
                    end else begin
                        e = exp_q.pop_front();
                        chk("txn_we", mem_we, e.we);
                        chk("txn_addr", mem_addr, e.addr);
                        if (e.we) chk("txn_wdata", mem_wdata, e.data);
                    end
                end else begin
                    cnt++;
                end
            end else begin
                pend    = 1'b0;
                cnt     = 0;
                rdata_m = 16'hDEAD;
            end
            if (ctl_nad || ctl_shr || ctl_shl || ctl_arg || ctl_read)
                chk("ctl_onehot", ctl_nad + ctl_shr + ctl_shl + ctl_arg + ctl_read, 1);
            if (mem_req || halted)
                chk("ctl_idle", {ctl_nad, ctl_shr, ctl_shl, ctl_arg, ctl_read}, 0);
            if (ctl_nad) begin
                nad_cycles++;
                nad_cyc = cyc;
            end
            if (fetch1_cyc < 0 && mem_req && !mem_we && mem_addr == 12'h001)
                fetch1_cyc = cyc;
        end
    end

    task automatic exp_rd(input logic [11:0] a);
        exp_q.push_back('{we: 1'b0, addr: a, data: 16'h0});
    endtask

    task automatic exp_wr(input logic [11:0] a, input logic [15:0] d);
        exp_q.push_back('{we: 1'b1, addr: a, data: d});
    endtask

    task automatic new_test();
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4096; i++) mem[i] = 16'h8000;
        exp_q.delete();
        delay      = 0;
        no_ack_en  = 1'b0;
        stray_ack  = 1'b0;
        req_cycles = 0;
        nad_cycles = 0;
        nad_cyc    = 0;
        fetch1_cyc = -1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_halt(input int max);
        for (int i = 0; i < max && !halted; i++) @(negedge clk);
        chk("halt_reached", halted, 1);
    endtask

    task automatic pulse_run();
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    initial begin
        logic found;
        rst = 1'b1; run = 1'b0; stray_ack = 1'b0; delay = 0;
        no_ack_en = 1'b0; no_ack_addr = '0; req_cycles = 0;
        nad_cycles = 0; nad_cyc = 0; fetch1_cyc = -1; req_seen = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = 16'h8000;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_pc", pc, 0);
        chk("rst_halted", halted, 0);
        chk("rst_error", error, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_acc", acc_data, 0);
        chk("rst_mem_data", mem_data, 0);
        chk("rst_arg_data", arg_data, 0);
        chk("rst_ctl", {ctl_nad, ctl_shr, ctl_shl, ctl_arg, ctl_read}, 0);
        rst = 1'b0;
        req_seen = 1'b0;
        repeat (6) @(negedge clk);
        chk("no_req_before_run", req_seen, 0);

        // LDI 0x00F; SHL; ST 0x100; HALT
        new_test();
        mem[0] = 16'h300F; mem[1] = 16'h2000; mem[2] = 16'h5100; mem[3] = 16'h8000;
        exp_rd(12'h000); exp_rd(12'h001); exp_rd(12'h002);
        exp_wr(12'h100, 16'h001E); exp_rd(12'h003);
        pulse_run();
        wait_halt(100);
        chk("p1_mem100", mem[12'h100], 16'h001E);
        chk("p1_error", error, 0);
        chk("p1_pc", pc, 12'h004);
        chk("p1_acc", acc_data, 16'h001E);
        chk("p1_q_empty", exp_q.size(), 0);

        // LDI 0x0FF; NAD 0x010; HALT
        new_test();
        mem[0] = 16'h30FF; mem[1] = 16'h0010; mem[2] = 16'h8000; mem[12'h010] = 16'h0F0F;
        exp_rd(12'h000); exp_rd(12'h001); exp_rd(12'h010); exp_rd(12'h002);
        pulse_run();
        wait_halt(100);
        chk("nad_acc", acc_data, 16'hFFF0);
        chk("nad_mem_data", mem_data, 16'h0F0F);
        chk("nad_ctl_cycles", nad_cycles, 1);
        chk("nad_instr_cycles", nad_cyc - fetch1_cyc + 1, 4);
        chk("nad_q_empty", exp_q.size(), 0);

        // JZ taken with acc=0
        new_test();
        mem[0] = 16'h3000; mem[1] = 16'h7020; mem[12'h020] = 16'h8000;
        exp_rd(12'h000); exp_rd(12'h001); exp_rd(12'h020);
        pulse_run();
        wait_halt(100);
        chk("jz_taken_pc", pc, 12'h021);
        chk("jz_taken_q_empty", exp_q.size(), 0);

        // JZ not taken with acc=1
        new_test();
        mem[0] = 16'h3001; mem[1] = 16'h7020; mem[2] = 16'h8000; mem[12'h020] = 16'h8000;
        exp_rd(12'h000); exp_rd(12'h001); exp_rd(12'h002);
        pulse_run();
        wait_halt(100);
        chk("jz_fall_pc", pc, 12'h003);
        chk("jz_fall_acc", acc_data, 16'h0001);
        chk("jz_fall_q_empty", exp_q.size(), 0);

        // Fetch with 3-cycle ack delay
        new_test();
        delay  = 3;
        mem[0] = 16'h8ABC;
        exp_rd(12'h000);
        pulse_run();
        @(negedge clk);
        chk("slow_req_mid", mem_req, 1);
        chk("slow_no_early_latch", arg_data, 16'h0000);
        wait_halt(100);
        chk("slow_req_cycles", req_cycles, 4);
        chk("slow_arg_data", arg_data, 16'h0ABC);
        chk("slow_pc", pc, 12'h001);
        chk("slow_error", error, 0);
        chk("slow_q_empty", exp_q.size(), 0);

        // Illegal opcode 0xA at pc=0x005
        new_test();
        mem[0] = 16'h6005; mem[5] = 16'hA123;
        exp_rd(12'h000); exp_rd(12'h005);
        pulse_run();
        wait_halt(100);
        chk("ill_halted", halted, 1);
        chk("ill_error", error, 1);
        chk("ill_pc", pc, 12'h006);
        req_seen = 1'b0;
        run = 1'b1;
        repeat (10) @(negedge clk);
        run = 1'b0;
        chk("ill_no_req", req_seen, 0);
        chk("ill_still_halted", halted, 1);
        chk("ill_q_empty", exp_q.size(), 0);

        // PC wrap on fetch from 0xFFF
        new_test();
        mem[0] = 16'h6FFF; mem[12'hFFF] = 16'h6010; mem[12'h010] = 16'h8000;
        exp_rd(12'h000); exp_rd(12'hFFF); exp_rd(12'h010);
        pulse_run();
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (mem_req && mem_addr == 12'hFFF) found = 1'b1;
        end
        chk("wrap_fetch_seen", found, 1);
        @(negedge clk);
        chk("wrap_pc_in_decode", pc, 12'h000);
        wait_halt(100);
        chk("wrap_final_pc", pc, 12'h011);
        chk("wrap_q_empty", exp_q.size(), 0);

        // Reset during an OPERAND wait, stray ack, then restart
        new_test();
        mem[0] = 16'h4030; mem[1] = 16'h8000; mem[12'h030] = 16'h1234;
        no_ack_en = 1'b1; no_ack_addr = 12'h030;
        exp_rd(12'h000);
        pulse_run();
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (mem_req && mem_addr == 12'h030) found = 1'b1;
        end
        chk("opwait_seen", found, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_mem_req", mem_req, 0);
        chk("arst_mem_addr", mem_addr, 0);
        chk("arst_pc", pc, 0);
        chk("arst_arg_data", arg_data, 0);
        chk("arst_halted", halted, 0);
        stray_ack = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_mem_req", mem_req, 0);
        chk("stray_pc", pc, 0);
        chk("stray_mem_data", mem_data, 0);
        stray_ack = 1'b0;
        chk("arst_q_empty", exp_q.size(), 0);
        no_ack_en = 1'b0;
        exp_rd(12'h000); exp_rd(12'h030); exp_rd(12'h001);
        pulse_run();
        wait_halt(100);
        chk("restart_acc", acc_data, 16'h1234);
        chk("restart_pc", pc, 12'h002);
        chk("restart_q_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ctl_sequencer.md
CTL_SEQUENCER -- requirements
Module: ctl_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, rising edge; rst  in  1  asynchronous, active-high reset.
REQ-002 SHALL have ports: run  in  1  start execution from IDLE; halted  out  1  HALT state reached; error  out  1  illegal opcode seen; pc  out  12  program counter.
REQ-003 SHALL have memory ports: mem_req  out  1; mem_we  out  1; mem_addr  out  12; mem_wdata  out  16; mem_rdata  in  16; mem_ack  in  1.
REQ-004 SHALL have ALU-side outputs: acc_data 16 (accumulator), mem_data 16 (operand register), arg_data 16 (zero-extended immediate), ctl_nad, ctl_shr, ctl_shl, ctl_arg, ctl_read, each 1.
REQ-005 SHALL have ALU-side inputs: alu_result  16  selected ALU result; alu_is_zero  1  accumulator equals zero.

Function
REQ-006 Instruction SHALL be opcode[15:12] and operand[11:0].
REQ-007 Opcodes: 0 NAD addr; 1 SHR; 2 SHL; 3 LDI imm; 4 LD addr; 5 ST addr; 6 JMP addr; 7 JZ addr; 8 HALT; 9-15 illegal.
REQ-008 States SHALL be IDLE, FETCH, DECODE, OPERAND, EXEC, STORE, HALT.
REQ-009 IDLE -> FETCH when run=1; run is ignored in all other states.
REQ-010 FETCH: mem_req=1, mem_we=0, mem_addr=pc; on mem_ack, latch mem_rdata into IR, pc <= pc+1 modulo 4096 (4095 wraps to 0), go to DECODE.
REQ-011 DECODE lasts exactly one cycle: NAD/LD -> OPERAND; ST -> STORE; SHR/SHL/LDI/JMP/JZ -> EXEC; HALT -> HALT; illegal -> HALT with error <= 1.
REQ-012 OPERAND: read request at mem_addr=operand; on mem_ack, latch mem_rdata into mem_data, go to EXEC.
REQ-013 EXEC lasts exactly one cycle and asserts one ctl line: NAD->ctl_nad, SHR->ctl_shr, SHL->ctl_shl, LDI->ctl_arg, LD->ctl_read; at its end acc <= alu_result, next state FETCH.
REQ-014 JMP in EXEC: pc <= operand, no ctl line, acc unchanged. JZ: pc <= operand only when alu_is_zero=1, else pc unchanged.
REQ-015 STORE: mem_req=1, mem_we=1, mem_addr=operand, mem_wdata=acc; on mem_ack -> FETCH.
REQ-016 ctl_* lines SHALL be one-hot in EXEC for ALU-op instructions and all zero in every other cycle.
REQ-017 Handshake: mem_req, mem_we, mem_addr and mem_wdata SHALL hold stable from assertion until the cycle mem_ack=1, inclusive; ack may arrive in the first req cycle.
REQ-018 mem_req SHALL deassert in the cycle after ack; mem_ack while mem_req=0 SHALL be ignored.
REQ-019 arg_data SHALL equal {4'b0, IR[11:0]} at all times.
REQ-020 HALT SHALL be terminal until rst: halted=1, mem_req=0, ctl_* all zero.
REQ-021 With ack in the first req cycle, cycle counts: NAD/LD 4; ST 3; SHR/SHL/LDI/JMP/JZ 3.

Reset
REQ-022 On rst: state IDLE, pc=0, acc_data=0, mem_data=0, IR=0, halted=0, error=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, ctl_* all 0.
REQ-023 rst asserted mid-handshake SHALL drop mem_req immediately (asynchronously); the outstanding ack has no effect.
REQ-024 After rst deasserts, no memory request before run=1.

Structure
REQ-025 Package ctl_pkg SHALL hold the opcode enum, state enum, ADDR_W=12 and DATA_W=16.
REQ-026 Opcode decode (IR -> next state, ctl select, illegal flag) SHALL be one combinational sub-module, ctl_decode; everything else lives in ctl_sequencer.

Verification
REQ-027 Program LDI 0x00F; SHL; ST 0x100; HALT with ALU model and zero-wait memory -> mem[0x100]=0x001E, halted=1, error=0, pc=4.
REQ-028 acc=0x00FF, NAD 0x010 with mem[0x010]=0x0F0F -> acc=0xFFF0; ctl_nad high exactly one cycle; 4 cycles total.
REQ-029 JZ 0x020 with acc=0 -> pc=0x020; with acc=1 -> pc advances by 1.
REQ-030 Memory ack delayed 3 cycles on fetch -> mem_req/mem_addr stable all 4 cycles, one IR latch, mem_req low the next cycle.
REQ-031 Opcode 0xA at pc=0x005 -> halted=1, error=1, no further mem_req; JMP at 0xFFF with pc wrap from 0xFFF fetch -> pc=0x000 before execution.
REQ-032 rst asserted during an OPERAND wait -> all outputs return to reset values at once; stray mem_ack ignored; restart via run executes from pc=0.
